// File: rtl/board_event_tracker.sv
// board_event_tracker: debounces 8x8 board frames, keeps the confirmed layout and
// streams per-square lift/place events over a valid/ready handshake.
module board_event_tracker #(
    parameter int STABLE_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_valid,
    input  logic [63:0] frame_data,
    input  logic        resync,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [5:0]  ev_square,
    output logic        ev_placed,
    output logic [63:0] stable_layout,
    output logic        init_done,
    output logic        stable
);
    localparam int CW = $clog2(STABLE_FRAMES + 1);
    localparam logic [CW-1:0] SF = CW'(STABLE_FRAMES);

    typedef enum logic [1:0] {INIT, IDLE, EMIT} state_t;

    state_t        state_q, state_d;
    logic [63:0]   cand_q, cand_d;
    logic [63:0]   diff_q, diff_d;
    logic [63:0]   pend_q, pend_d;
    logic [63:0]   layout_q, layout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          init_q, init_d;
    logic [5:0]    low_sq;
    logic          confirmed, accept, last;

    always_comb begin
        low_sq = '0;
        for (int i = 63; i >= 0; i--)
            if (diff_q[i]) low_sq = 6'(i);
    end

    assign confirmed     = cnt_q == SF;
    assign accept        = (state_q == EMIT) && ev_ready;
    assign last          = (diff_q & ~(64'd1 << low_sq)) == '0;
    assign ev_valid      = state_q == EMIT;
    assign ev_square     = ev_valid ? low_sq : '0;
    assign ev_placed     = ev_valid & pend_q[low_sq];
    assign stable_layout = layout_q;
    assign init_done     = init_q;
    assign stable        = (state_q == IDLE) && confirmed && (cand_q == layout_q);

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        pend_d   = pend_q;
        layout_d = layout_q;
        init_d   = init_q;
        if (frame_valid) begin
            cand_d = frame_data;
            cnt_d  = (frame_data != cand_q) ? CW'(1) : confirmed ? cnt_q : cnt_q + CW'(1);
        end
        case (state_q)
            INIT: if (confirmed) begin
                layout_d = cand_q;
                init_d   = 1'b1;
                state_d  = IDLE;
            end
            IDLE: if (confirmed && cand_q != layout_q) begin
                diff_d  = cand_q ^ layout_q;
                pend_d  = cand_q;
                state_d = EMIT;
            end
            EMIT: if (accept) begin
                diff_d[low_sq]   = 1'b0;
                layout_d[low_sq] = pend_q[low_sq];
                state_d          = last ? IDLE : EMIT;
            end
            default: state_d = INIT;
        endcase
        // resync overrides everything, including a same-cycle accept
        if (resync) begin
            state_d  = INIT;
            cnt_d    = '0;
            diff_d   = '0;
            init_d   = 1'b0;
            layout_d = layout_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= INIT;
            cand_q   <= '0;
            cnt_q    <= '0;
            diff_q   <= '0;
            pend_q   <= '0;
            layout_q <= '0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            pend_q   <= pend_d;
            layout_q <= layout_d;
            init_q   <= init_d;
        end
    end
endmodule

// File: tb/tb_board_event_tracker.sv
// tb_board_event_tracker: directed scenarios plus random frames, checked every cycle
// against a queue-based model of the tracker.
module tb_board_event_tracker;
    localparam int SF = 3;
    localparam logic [63:0] A = 64'hFFFF00000000FFFF;

    logic        clk = 1'b0;
    logic        reset, frame_valid, resync, ev_ready;
    logic [63:0] frame_data;
    logic        ev_valid, ev_placed, init_done, stable;
    logic [5:0]  ev_square;
    logic [63:0] stable_layout;

    int nvec = 0;
    int nerr = 0;

    logic [63:0] m_cand, m_sl, m_pend;
    int          m_cnt;
    bit          m_init;
    int          q[$];

    always #5 clk = ~clk;

    board_event_tracker #(.STABLE_FRAMES(SF)) dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_data(frame_data),
        .resync(resync), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_square(ev_square),
        .ev_placed(ev_placed), .stable_layout(stable_layout), .init_done(init_done),
        .stable(stable)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cand = '0; m_sl = '0; m_pend = '0; m_cnt = 0; m_init = 0;
        q.delete();
    endtask

    // One clock edge of the model; the pending-event list is a queue of squares.
    task automatic step(input logic fv, input logic [63:0] fd, input logic rs, input logic rdy);
        bit conf;
        int s;
        conf = (m_cnt == SF);
        if (rs) begin
            q.delete();
            m_init = 0;
        end else if (!m_init) begin
            if (conf) begin m_sl = m_cand; m_init = 1; end
        end else if (q.size() == 0) begin
            if (conf && m_cand != m_sl) begin
                m_pend = m_cand;
                for (int i = 0; i < 64; i++) if (m_cand[i] != m_sl[i]) q.push_back(i);
            end
        end else if (rdy) begin
            s = q.pop_front();
            m_sl[s] = m_pend[s];
        end
        if (fv) begin
            if (fd == m_cand) m_cnt = (m_cnt + 1 > SF) ? SF : m_cnt + 1;
            else begin m_cand = fd; m_cnt = 1; end
        end
        if (rs) m_cnt = 0;
    endtask

    task automatic compare();
        bit   v;
        int   s;
        v = q.size() > 0;
        s = v ? q[0] : 0;
        chk("ev_valid", 64'(ev_valid), 64'(v));
        chk("ev_square", 64'(ev_square), 64'(s));
        chk("ev_placed", 64'(ev_placed), v ? 64'(m_pend[s]) : 64'd0);
        chk("stable_layout", stable_layout, m_sl);
        chk("init_done", 64'(init_done), 64'(m_init));
        chk("stable", 64'(stable), 64'(m_init && !v && m_cnt == SF && m_cand == m_sl));
    endtask

    task automatic tick(input logic fv, input logic [63:0] fd, input logic rs, input logic rdy);
        frame_valid = fv; frame_data = fd; resync = rs; ev_ready = rdy;
        step(fv, fd, rs, rdy);
        @(posedge clk);
        @(negedge clk);
        frame_valid = 1'b0; resync = 1'b0;
        compare();
    endtask

    task automatic confirm(input logic [63:0] f);
        int n;
        repeat (SF) tick(1'b1, f, 1'b0, 1'b1);
        n = 0;
        tick(1'b0, '0, 1'b0, 1'b1);
        while (q.size() > 0 && n < 80) begin tick(1'b0, '0, 1'b0, 1'b1); n++; end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] l1, b, p, c1, c2, base, f;
        reset = 1'b1; frame_valid = 1'b0; frame_data = '0; resync = 1'b0; ev_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        reset = 1'b0;

        // init capture
        repeat (SF) tick(1'b1, A, 1'b0, 1'b1);
        chk("init_before", 64'(init_done), 64'd0);
        repeat (2) tick(1'b0, '0, 1'b0, 1'b1);
        chk("init_done", 64'(init_done), 64'd1);
        chk("init_layout", stable_layout, A);
        chk("init_stable", 64'(stable), 64'd1);
        chk("init_no_ev", 64'(ev_valid), 64'd0);

        // single lift
        l1 = A & ~(64'd1 << 8);
        repeat (SF) tick(1'b1, l1, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("lift_valid", 64'(ev_valid), 64'd1);
        chk("lift_sq", 64'(ev_square), 64'd8);
        chk("lift_placed", 64'(ev_placed), 64'd0);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("lift_layout", stable_layout, l1);
        chk("lift_done", 64'(ev_valid), 64'd0);
        confirm(A);

        // bounce rejection
        b = A & ~(64'd1 << 12);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, (i % 2 == 0) ? b : A, 1'b0, 1'b1);
            chk("bounce_stable", 64'(stable), 64'd0);
            chk("bounce_no_ev", 64'(ev_valid), 64'd0);
        end
        repeat (SF) tick(1'b1, A, 1'b0, 1'b1);
        chk("bounce_settle", 64'(stable), 64'd1);

        // backpressure on a two-square change
        p = (A & ~(64'd1 << 8)) | (64'd1 << 24);
        repeat (SF) tick(1'b1, p, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, '0, 1'b0, 1'b0);
            chk("bp_valid", 64'(ev_valid), 64'd1);
            chk("bp_sq", 64'(ev_square), 64'd8);
            chk("bp_placed", 64'(ev_placed), 64'd0);
        end
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("bp_sq2", 64'(ev_square), 64'd24);
        chk("bp_placed2", 64'(ev_placed), 64'd1);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("bp_end", 64'(ev_valid), 64'd0);
        chk("bp_layout", stable_layout, 64'hFFFF00000100FEFF);

        // new layout confirmed while events are still pending
        c1 = p ^ (64'd1 << 3) ^ (64'd1 << 40);
        c2 = c1 ^ (64'd1 << 50);
        repeat (SF) tick(1'b1, c1, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        repeat (SF) tick(1'b1, c2, 1'b0, 1'b0);
        chk("emit_hold_sq", 64'(ev_square), 64'd3);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("emit_sq40", 64'(ev_square), 64'd40);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("emit_idle", 64'(ev_valid), 64'd0);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("emit_sq50", 64'(ev_square), 64'd50);
        chk("emit_pl50", 64'(ev_placed), 64'd0);
        tick(1'b0, '0, 1'b0, 1'b1);

        // asynchronous reset while an event is presented
        repeat (SF) tick(1'b1, A, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        chk("rst_pre", 64'(ev_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_valid", 64'(ev_valid), 64'd0);
        chk("rst_sq", 64'(ev_square), 64'd0);
        chk("rst_layout", stable_layout, 64'd0);
        chk("rst_init", 64'(init_done), 64'd0);
        chk("rst_stable", 64'(stable), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        compare();

        // resync while an event is presented, with a same-cycle accept
        confirm(A);
        repeat (SF) tick(1'b1, p, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b1);
        chk("rs_valid", 64'(ev_valid), 64'd0);
        chk("rs_init", 64'(init_done), 64'd0);
        chk("rs_layout", stable_layout, A);
        repeat (SF - 1) tick(1'b1, A, 1'b0, 1'b1);
        chk("rs_wait", 64'(init_done), 64'd0);
        tick(1'b1, A, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("rs_reinit", 64'(init_done), 64'd1);
        chk("rs_no_ev", 64'(ev_valid), 64'd0);

        // random frames, bounces, backpressure and occasional resync
        base = A;
        for (int n = 0; n < 4000; n++) begin
            logic fv, rs;
            if ($urandom_range(0, 24) == 0) base ^= 64'd1 << $urandom_range(0, 63);
            if ($urandom_range(0, 60) == 0) base ^= 64'd1 << $urandom_range(0, 63);
            f = ($urandom_range(0, 4) == 0) ? base ^ (64'd1 << $urandom_range(0, 63)) : base;
            fv = 1'($urandom_range(0, 1));
            rs = !fv && $urandom_range(0, 299) == 0;
            tick(fv, f, rs, $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/board_event_tracker.md
# board_event_tracker

Sits downstream of the 8x8 reed-switch matrix scanner and sequences how its frames are consumed. It debounces full-board frames by requiring STABLE_FRAMES consecutive identical frames. It keeps the last confirmed board layout. It serialises every square difference into a valid/ready stream of lift/place events for the move-decoding logic, one square at a time.

## Interface
- STABLE_FRAMES, default 3: number of consecutive identical frames that confirm a layout; legal range ≥1.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- frame_valid  in  1  one-cycle pulse from the scanner: frame_data is a complete new frame.
- frame_data  in  64  board frame; bit i = square i; bits [63:56] = row 0, [7:0] = row 7; 1 = piece present.
- resync  in  1  synchronous one-cycle pulse: discard history and re-acquire the board without emitting events.
- ev_valid  out  1  an event is presented.
- ev_ready  in  1  consumer accepts the event when high together with ev_valid.
- ev_square  out  6  square index (bit number) of the event.
- ev_placed  out  1  1 = piece placed, 0 = piece lifted.
- stable_layout  out  64  last confirmed layout, updated per accepted event.
- init_done  out  1  first layout has been confirmed.
- stable  out  1  board is settled and fully reported.

## Operation
- Registers:
  - cand[63:0]: candidate frame.
  - cnt: width $clog2(STABLE_FRAMES+1), saturating.
  - diff[63:0]: pending changes.
  - pend[63:0]: target layout.
  - stable_layout.
- Debounce, active in every state:
  - On frame_valid with frame_data == cand: cnt <= min(cnt+1, STABLE_FRAMES).
  - On frame_valid with frame_data != cand: cand <= frame_data, cnt <= 1.
- "Confirmed" means cnt == STABLE_FRAMES.
- FSM states: INIT, IDLE, EMIT.
- INIT:
  - If confirmed: stable_layout <= cand, init_done <= 1, go IDLE.
  - No events are produced.
- IDLE:
  - If confirmed and cand != stable_layout: diff <= cand ^ stable_layout, pend <= cand, go EMIT.
  - The condition is level-based. A layout confirmed during EMIT is picked up on the first IDLE cycle.
- EMIT:
  - ev_valid = 1.
  - ev_square = index of the lowest set bit of diff.
  - ev_placed = pend[ev_square].
  - On accept (ev_valid && ev_ready):
    - diff[ev_square] <= 0.
    - stable_layout[ev_square] <= pend[ev_square].
    - If this was the last set bit of diff, go IDLE.
- Frames arriving during EMIT update cand/cnt only. They never alter diff or pend.
- resync, any state:
  - state <= INIT, cnt <= 0, diff <= 0, init_done <= 0.
  - ev_valid drops the next cycle.
  - stable_layout is retained until the next INIT capture.
- stable = (state == IDLE) && confirmed && (cand == stable_layout).
- Outside EMIT: ev_valid, ev_square and ev_placed are 0.

## Timing
- Reset values:
  - state INIT; cand, cnt, diff, pend and stable_layout all 0.
  - All outputs 0.
- Latency: frame sampled at edge k makes cnt == STABLE_FRAMES. The IDLE decision loads diff at edge k+1. ev_valid is high in the cycle after edge k+1.
- INIT capture: stable_layout and init_done update at edge k+1 under the same rule.
- Handshake:
  - ev_square and ev_placed stay stable while ev_valid && !ev_ready.
  - ev_valid never deasserts without acceptance, except on reset or resync.
- Throughput: one event per cycle while ev_ready is held high.
- After the last accept, the FSM spends at least one cycle in IDLE before the next EMIT.
- Event ordering: ascending square index within one confirmed change.
- frame_valid and accept in the same cycle are both honoured.
- resync and accept in the same cycle: resync wins and stable_layout is not updated.
- STABLE_FRAMES = 1: every frame is confirmed immediately. cnt saturates at 1.

## Test plan
- Init capture:
  - Stimulus: reset, then 3 frames of 0xFFFF00000000FFFF.
  - Response: init_done = 1 and stable_layout = 0xFFFF00000000FFFF two edges after the third frame. ev_valid never asserts. stable = 1 afterwards.
- Single lift:
  - Stimulus: after init, 3 frames with bit 8 cleared.
  - Response: exactly one event, ev_square = 8, ev_placed = 0. stable_layout bit 8 = 0 after accept.
- Bounce rejection:
  - Stimulus: after init, frames B, A, B, A, where B = A with bit 12 cleared.
  - Response: no event. cnt never exceeds 1 for B. stable stays low during the sequence and returns high after 3 frames of A.
- Capture with backpressure:
  - Stimulus: one confirmed change clears bit 8 and sets bit 24. Hold ev_ready low for 5 cycles.
  - Response: ev_valid = 1 with square 8, placed 0, held for all 5 cycles. With ev_ready high: square 8 accepted, then square 24 with placed 1 on the next cycle. ev_valid = 0 after the second accept.
- Change during EMIT:
  - Stimulus: confirm a 2-bit change, hold ev_ready low, and confirm a third layout meanwhile.
  - Response: the first two events complete unchanged. After one IDLE cycle, the events for the new layout are reported relative to the updated stable_layout.
- Reset/resync mid-EMIT:
  - Stimulus: assert reset while ev_valid = 1.
  - Response: all outputs 0 immediately and state INIT.
  - Stimulus: repeat with resync.
  - Response: ev_valid = 0 the next cycle. init_done = 0 until 3 identical frames re-confirm, with no events emitted.
